mem_loader: RTL and testbench
=============================

Name: mem_loader

Overview:
- Hardware replacement for the bench's file-driven memory programming and dump.
- Consumes a byte stream over a valid/ready link and executes four commands: load imem, load dmem, dump dmem, run.
- Writes both memories, holds the CPU in reset while programming, and releases reset after a cool-off count.
- Sits upstream of noobs_cpu, between the host link and the u_inst_mem/u_data_mem ports.

Parameters:
- ADDR_W, 12, memory address width; addresses wrap modulo 2^ADDR_W.
- COOLOFF, 32, cycles between the run command and cpu_reset_ deassertion; legal range 1..255.
- DMEM_BASE, 8, offset added to every dmem address; the first 8 dmem locations are special purpose.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_  in  1  asynchronous, active-low reset.
- rx_data  in  8  command/data byte from host.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts rx_data this cycle.
- tx_data  out  8  dump byte to host.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  host accepts tx_data.
- i_addr  out  ADDR_W  imem address.
- i_wr_data  out  8  imem write data.
- i_wr  out  1  imem write strobe, one cycle per byte.
- d_addr  out  ADDR_W  dmem address; already includes DMEM_BASE.
- d_wr_data  out  8  dmem write data.
- d_wr  out  1  dmem write strobe.
- d_rd  out  1  dmem read strobe.
- d_rd_data  in  8  dmem read data, valid 1 cycle after d_rd.
- cpu_halted  in  1  CPU halt indication.
- cpu_reset_  out  1  active-low CPU reset.
- err  out  1  sticky protocol error.

Behaviour:
- Reset values: rx_ready=0, tx_valid=0, tx_data=0, i_wr=0, d_wr=0, d_rd=0, all addresses and data outputs 0, cpu_reset_=0, err=0, state=IDLE.
- Handshake: a byte transfers when rx_valid&&rx_ready (same rule for tx). tx_data/tx_valid hold stable until tx_ready. rx_ready is 1 only in IDLE, HDR and LOAD.
- Command byte (IDLE):
  - 0x01 load imem, 0x02 load dmem, 0x03 dump dmem: go to HDR.
  - 0x04 run: go to COOLOFF.
  - Any other value: err<=1, stay IDLE, byte discarded.
- HDR: accepts exactly 4 bytes: addr_hi[3:0], addr_lo, len_hi[3:0], len_lo; upper nibbles of the hi bytes are ignored.
  - len==0 returns to IDLE with no memory access.
  - Otherwise go to LOAD (0x01/0x02) or DUMP_RD (0x03).
- cpu_reset_ is driven 0 on the same edge that accepts a 0x01/0x02/0x03 command, and stays 0 until a run completes.
- LOAD: each accepted byte produces a write strobe in the next cycle with the current address; the address then increments (wrap 0xFFF->0x000).
  - dmem address = (addr+DMEM_BASE) mod 2^ADDR_W.
  - After len bytes, return to IDLE.
  - Throughput: 1 byte/cycle.
- DUMP_RD: pulse d_rd for one cycle, then DUMP_TX.
- DUMP_TX: capture d_rd_data the cycle after d_rd and present it with tx_valid=1; on tx_ready, increment address and decrement the count.
  - If bytes remain, return to DUMP_RD; otherwise go to IDLE.
  - Throughput: at most 1 byte per 2 cycles.
- COOLOFF: the counter counts COOLOFF cycles, then cpu_reset_<=1 and the state goes to RUN.
- RUN: rx_ready=0 until cpu_halted=1, then IDLE. cpu_reset_ stays 1, so a halted CPU is inspectable by dump.
- A 0x04 while cpu_reset_ is already 1 in IDLE re-runs COOLOFF without dropping reset.
- Simultaneous events: a write strobe and a new command byte may coincide; the strobe uses the previous command's registers.
- reset_ asserted mid-operation: all state returns to reset values immediately. A partial load is not resumed.
- err is cleared only by reset_.

Optional Feature:
- MEM_LOADER_CHECKSUM_EN defined:
  - Load commands expect one trailing byte after the data, equal to the 8-bit two's-complement of the sum of all data bytes (mod 256).
  - A mismatch sets err. Data is already written, and the state returns to IDLE normally.
  - Dump appends one extra tx byte carrying the same checksum over the dumped bytes.
- Not defined: no trailing byte on load or dump; no checksum logic.

Decomposition:
- Shared package noobs_loader_pkg holds:
  - command codes CMD_LOAD_I=0x01, CMD_LOAD_D=0x02, CMD_DUMP_D=0x03, CMD_RUN=0x04;
  - the state enum IDLE/HDR/LOAD/DUMP_RD/DUMP_TX/COOLOFF/RUN;
  - header byte count 4.
- One sub-module is natural: loader_cmd_parser, covering IDLE/HDR byte assembly into {cmd, addr, len}. The data mover stays in the top.

Test Plan:
- Load imem: send 01 00 10 00 03 AA BB CC -> i_wr pulses at addr 0x010/0x011/0x012 with AA/BB/CC; cpu_reset_=0 throughout.
- Load dmem with wrap: send 02 0F FE 00 04 11 22 33 44 -> d_wr at 0x006,0x007,0x008,0x009 (0xFFE+8 wraps); returns to IDLE.
- Run: send 04 -> cpu_reset_ rises exactly COOLOFF(32) cycles after acceptance; rx_ready=0 until cpu_halted=1.
- Dump with backpressure: preload dmem 0x008..0x009=5A,A5; send 03 00 00 00 02 with tx_ready low for 5 cycles -> tx_data holds 5A stable, then 5A, A5 emitted; tx_valid drops.
- Errors and zero length: send 07 -> err=1, next 01 00 00 00 00 -> no i_wr, IDLE; err remains 1 until reset_.
- Reset mid-load: assert reset_ after 2 of 4 data bytes -> all outputs at reset values asynchronously; no further strobes after deassertion.

Source files
------------

// File: rtl/mem_loader_pkg.sv
`timescale 1ns/1ps
// Shared command codes, FSM states and header layout for the host-driven memory loader.
// Optional checksum trailer on load/dump is enabled by defining MEM_LOADER_CHECKSUM_EN.
package noobs_loader_pkg;

  localparam int unsigned HDR_BYTES   = 4;
  localparam int unsigned HDR_IDX_W   = $clog2(HDR_BYTES);
  localparam int unsigned HDR_FIELD_W = 12;

  localparam logic [7:0] CMD_LOAD_I = 8'h01;
  localparam logic [7:0] CMD_LOAD_D = 8'h02;
  localparam logic [7:0] CMD_DUMP_D = 8'h03;
  localparam logic [7:0] CMD_RUN    = 8'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOAD,
    ST_DUMP_RD,
    ST_DUMP_TX,
    ST_COOLOFF,
    ST_RUN
  } state_e;

  typedef struct packed {
    logic [7:0]             cmd;
    logic [HDR_FIELD_W-1:0] addr;
    logic [HDR_FIELD_W-1:0] len;
  } ldr_hdr_t;

  // Commands that carry a 4-byte address/length header.
  function automatic logic is_xfer_cmd(input logic [7:0] b);
    return (b == CMD_LOAD_I) || (b == CMD_LOAD_D) || (b == CMD_DUMP_D);
  endfunction

endpackage

// File: rtl/mem_loader_if.sv
`timescale 1ns/1ps
// Host byte link plus instruction/data memory ports driven by the loader.
interface mem_loader_if #(
  parameter int unsigned ADDR_W = 12
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [ADDR_W-1:0] i_addr;
  logic [7:0]        i_wr_data;
  logic              i_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [7:0]        d_wr_data;
  logic              d_wr;
  logic              d_rd;
  logic [7:0]        d_rd_data;

  modport master (
    input  rx_data, rx_valid, tx_ready, d_rd_data,
    output rx_ready, tx_data, tx_valid, i_addr, i_wr_data, i_wr,
           d_addr, d_wr_data, d_wr, d_rd
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, d_rd_data,
    input  rx_ready, tx_data, tx_valid, i_addr, i_wr_data, i_wr,
           d_addr, d_wr_data, d_wr, d_rd
  );
endinterface

// File: rtl/mem_loader_cmd_parser.sv
`timescale 1ns/1ps
// Assembles the command byte and the 4-byte address/length header into one record.
module loader_cmd_parser
  import noobs_loader_pkg::*;
(
  input  logic       clk,
  input  logic       reset_,
  input  logic [7:0] rx_byte,
  input  logic       cmd_take,
  input  logic       hdr_take,
  output ldr_hdr_t   hdr_c,
  output logic       hdr_last_c
);

  logic [7:0]             cmd_q;
  logic [HDR_FIELD_W-1:0] addr_q;
  logic [3:0]             len_hi_q;
  logic [HDR_IDX_W-1:0]   idx_q;

  // Upper nibbles of the hi bytes are dropped.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      cmd_q    <= '0;
      addr_q   <= '0;
      len_hi_q <= '0;
      idx_q    <= '0;
    end else if (cmd_take) begin
      cmd_q <= rx_byte;
      idx_q <= '0;
    end else if (hdr_take) begin
      idx_q <= idx_q + HDR_IDX_W'(1);
      case (idx_q)
        HDR_IDX_W'(0): addr_q[11:8] <= rx_byte[3:0];
        HDR_IDX_W'(1): addr_q[7:0]  <= rx_byte;
        HDR_IDX_W'(2): len_hi_q     <= rx_byte[3:0];
        default: ;
      endcase
    end
  end

  // The final length byte is still on the link when the header completes.
  always_comb begin
    hdr_c      = '0;
    hdr_c.cmd  = cmd_q;
    hdr_c.addr = addr_q;
    hdr_c.len  = {len_hi_q, rx_byte};
    hdr_last_c = hdr_take && (idx_q == HDR_IDX_W'(HDR_BYTES - 1));
  end

endmodule

// File: rtl/mem_loader.sv
`timescale 1ns/1ps
// Byte-stream memory loader: programs imem/dmem, dumps dmem, and sequences CPU reset release.
// Define MEM_LOADER_CHECKSUM_EN for a trailing two's-complement checksum byte on load and dump.
module mem_loader
  import noobs_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned COOLOFF   = 32,
  parameter int unsigned DMEM_BASE = 8
) (
  input  logic         clk,
  input  logic         reset_,
  mem_loader_if.master bus,
  input  logic         cpu_halted,
  output logic         cpu_reset_,
  output logic         err
);

  localparam int unsigned COOL_W = 8;
  localparam int unsigned CNT_W  = HDR_FIELD_W;

  state_e            state, state_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [CNT_W-1:0]  cnt_q, cnt_nx;
  logic [COOL_W-1:0] cool_q, cool_nx;
  logic              rx_ready_q, rx_ready_nx;
  logic [7:0]        tx_data_q, tx_data_nx;
  logic              tx_valid_q, tx_valid_nx;
  logic [ADDR_W-1:0] i_addr_q, i_addr_nx;
  logic [7:0]        i_wr_data_q, i_wr_data_nx;
  logic              i_wr_q, i_wr_nx;
  logic [ADDR_W-1:0] d_addr_q, d_addr_nx;
  logic [7:0]        d_wr_data_q, d_wr_data_nx;
  logic              d_wr_q, d_wr_nx;
  logic              d_rd_q, d_rd_nx;
  logic              cpu_reset_q, cpu_reset_nx;
  logic              err_q, err_nx;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic              csum_q, csum_nx;
  logic [7:0]        sum_q, sum_nx;
`endif

  ldr_hdr_t hdr_c;
  logic     hdr_last_c;
  logic     rx_fire_c;
  logic     tx_fire_c;

  assign rx_fire_c = bus.rx_valid && rx_ready_q;
  assign tx_fire_c = tx_valid_q && bus.tx_ready;

  function automatic logic [ADDR_W-1:0] dmem_addr(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(DMEM_BASE);
  endfunction

  loader_cmd_parser u_parser (
    .clk        (clk),
    .reset_     (reset_),
    .rx_byte    (bus.rx_data),
    .cmd_take   (rx_fire_c && (state == ST_IDLE)),
    .hdr_take   (rx_fire_c && (state == ST_HDR)),
    .hdr_c      (hdr_c),
    .hdr_last_c (hdr_last_c)
  );

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      cool_q      <= '0;
      rx_ready_q  <= 1'b0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      i_addr_q    <= '0;
      i_wr_data_q <= '0;
      i_wr_q      <= 1'b0;
      d_addr_q    <= '0;
      d_wr_data_q <= '0;
      d_wr_q      <= 1'b0;
      d_rd_q      <= 1'b0;
      cpu_reset_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
      csum_q      <= 1'b0;
      sum_q       <= '0;
`endif
    end else begin
      state       <= state_nx;
      addr_q      <= addr_nx;
      cnt_q       <= cnt_nx;
      cool_q      <= cool_nx;
      rx_ready_q  <= rx_ready_nx;
      tx_data_q   <= tx_data_nx;
      tx_valid_q  <= tx_valid_nx;
      i_addr_q    <= i_addr_nx;
      i_wr_data_q <= i_wr_data_nx;
      i_wr_q      <= i_wr_nx;
      d_addr_q    <= d_addr_nx;
      d_wr_data_q <= d_wr_data_nx;
      d_wr_q      <= d_wr_nx;
      d_rd_q      <= d_rd_nx;
      cpu_reset_q <= cpu_reset_nx;
      err_q       <= err_nx;
`ifdef MEM_LOADER_CHECKSUM_EN
      csum_q      <= csum_nx;
      sum_q       <= sum_nx;
`endif
    end
  end

  // Next state and next registered outputs; strobes default low, everything else holds.
  always_comb begin
    state_nx     = state;
    addr_nx      = addr_q;
    cnt_nx       = cnt_q;
    cool_nx      = cool_q;
    tx_data_nx   = tx_data_q;
    tx_valid_nx  = tx_valid_q;
    i_addr_nx    = i_addr_q;
    i_wr_data_nx = i_wr_data_q;
    i_wr_nx      = 1'b0;
    d_addr_nx    = d_addr_q;
    d_wr_data_nx = d_wr_data_q;
    d_wr_nx      = 1'b0;
    d_rd_nx      = 1'b0;
    cpu_reset_nx = cpu_reset_q;
    err_nx       = err_q;
`ifdef MEM_LOADER_CHECKSUM_EN
    csum_nx      = csum_q;
    sum_nx       = sum_q;
`endif

    case (state)
      ST_IDLE: begin
        if (rx_fire_c) begin
          if (is_xfer_cmd(bus.rx_data)) begin
            state_nx     = ST_HDR;
            cpu_reset_nx = 1'b0;
          end else if (bus.rx_data == CMD_RUN) begin
            state_nx = ST_COOLOFF;
            cool_nx  = COOL_W'(COOLOFF - 1);
          end else begin
            err_nx = 1'b1;
          end
        end
      end

      ST_HDR: begin
        if (hdr_last_c) begin
          if (hdr_c.len == '0) begin
            state_nx = ST_IDLE;
          end else begin
            addr_nx = ADDR_W'(hdr_c.addr);
            cnt_nx  = hdr_c.len;
`ifdef MEM_LOADER_CHECKSUM_EN
            csum_nx = 1'b0;
            sum_nx  = '0;
`endif
            if (hdr_c.cmd == CMD_DUMP_D) begin
              state_nx  = ST_DUMP_RD;
              d_rd_nx   = 1'b1;
              d_addr_nx = dmem_addr(ADDR_W'(hdr_c.addr));
            end else begin
              state_nx = ST_LOAD;
            end
          end
        end
      end

      ST_LOAD: begin
        if (rx_fire_c) begin
`ifdef MEM_LOADER_CHECKSUM_EN
          if (csum_q) begin
            err_nx   = err_q | (bus.rx_data != 8'(8'd0 - sum_q));
            csum_nx  = 1'b0;
            state_nx = ST_IDLE;
          end else begin
            sum_nx = sum_q + bus.rx_data;
`endif
            if (hdr_c.cmd == CMD_LOAD_I) begin
              i_wr_nx      = 1'b1;
              i_addr_nx    = addr_q;
              i_wr_data_nx = bus.rx_data;
            end else begin
              d_wr_nx      = 1'b1;
              d_addr_nx    = dmem_addr(addr_q);
              d_wr_data_nx = bus.rx_data;
            end
            addr_nx = addr_q + ADDR_W'(1);
            cnt_nx  = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
`ifdef MEM_LOADER_CHECKSUM_EN
              csum_nx = 1'b1;
`else
              state_nx = ST_IDLE;
`endif
            end
`ifdef MEM_LOADER_CHECKSUM_EN
          end
`endif
        end
      end

      ST_DUMP_RD: state_nx = ST_DUMP_TX;

      // Read data lands during the first DUMP_TX cycle and is captured at its end.
      ST_DUMP_TX: begin
        if (!tx_valid_q) begin
          tx_data_nx  = bus.d_rd_data;
          tx_valid_nx = 1'b1;
        end else if (tx_fire_c) begin
          tx_valid_nx = 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
          if (csum_q) begin
            csum_nx  = 1'b0;
            state_nx = ST_IDLE;
          end else begin
            sum_nx = sum_q + tx_data_q;
`endif
            addr_nx = addr_q + ADDR_W'(1);
            cnt_nx  = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
`ifdef MEM_LOADER_CHECKSUM_EN
              csum_nx     = 1'b1;
              tx_valid_nx = 1'b1;
              tx_data_nx  = 8'(8'd0 - sum_nx);
`else
              state_nx = ST_IDLE;
`endif
            end else begin
              state_nx  = ST_DUMP_RD;
              d_rd_nx   = 1'b1;
              d_addr_nx = dmem_addr(addr_q + ADDR_W'(1));
            end
`ifdef MEM_LOADER_CHECKSUM_EN
          end
`endif
        end
      end

      ST_COOLOFF: begin
        if (cool_q == '0) begin
          cpu_reset_nx = 1'b1;
          state_nx     = ST_RUN;
        end else begin
          cool_nx = cool_q - COOL_W'(1);
        end
      end

      ST_RUN: begin
        if (cpu_halted) state_nx = ST_IDLE;
      end

      default: state_nx = ST_IDLE;
    endcase

    rx_ready_nx = (state_nx == ST_IDLE) || (state_nx == ST_HDR) || (state_nx == ST_LOAD);
  end

  assign bus.rx_ready  = rx_ready_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.i_addr    = i_addr_q;
  assign bus.i_wr_data = i_wr_data_q;
  assign bus.i_wr      = i_wr_q;
  assign bus.d_addr    = d_addr_q;
  assign bus.d_wr_data = d_wr_data_q;
  assign bus.d_wr      = d_wr_q;
  assign bus.d_rd      = d_rd_q;
  assign cpu_reset_    = cpu_reset_q;
  assign err           = err_q;

endmodule

// File: tb/tb_mem_loader.sv
`timescale 1ns/1ps
// Directed bench for mem_loader: imem load, dmem wrap, run cool-off, dump backpressure, errors, reset.
module tb_mem_loader;

  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned COOLOFF   = 32;
  localparam int unsigned DMEM_BASE = 8;
`ifdef MEM_LOADER_CHECKSUM_EN
  localparam int N_DUMP = 3;
`else
  localparam int N_DUMP = 2;
`endif

  logic        clk = 1'b0;
  logic        reset_;
  logic        cpu_halted;
  logic        cpu_reset_;
  logic        err;
  logic [7:0]  rd_q;
  logic [7:0]  dmem [4096];
  logic [19:0] iw_q [$];
  logic [19:0] dw_q [$];
  logic [7:0]  tx_q [$];
  int          n_chk = 0;
  int          n_pass = 0;

  logic [19:0] exp_i [3] = '{20'h010AA, 20'h011BB, 20'h012CC};
  logic [19:0] exp_d [4] = '{20'h00611, 20'h00722, 20'h00833, 20'h00944};
  logic [7:0]  exp_tx [3] = '{8'h5A, 8'hA5, 8'h01};

  mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  mem_loader #(
    .ADDR_W    (ADDR_W),
    .COOLOFF   (COOLOFF),
    .DMEM_BASE (DMEM_BASE)
  ) dut (
    .clk        (clk),
    .reset_     (reset_),
    .bus        (bus),
    .cpu_halted (cpu_halted),
    .cpu_reset_ (cpu_reset_),
    .err        (err)
  );

  always #5 clk = ~clk;

  assign bus.d_rd_data = rd_q;

  // Memory models and traffic logs.
  always @(posedge clk) begin
    if (bus.i_wr) iw_q.push_back({bus.i_addr, bus.i_wr_data});
    if (bus.d_wr) begin
      dw_q.push_back({bus.d_addr, bus.d_wr_data});
      dmem[bus.d_addr] <= bus.d_wr_data;
    end
    if (bus.d_rd) rd_q <= dmem[bus.d_addr];
    if (bus.tx_valid && bus.tx_ready) tx_q.push_back(bus.tx_data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("rx_ready_timeout", 32'(t), 32'd0);
    @(posedge clk);
    #1 bus.rx_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int n0;

    reset_       = 1'b0;
    cpu_halted   = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b0;
    wait_cycles(3);
    check("rst_rx_ready",  32'(bus.rx_ready),  32'd0);
    check("rst_tx_valid",  32'(bus.tx_valid),  32'd0);
    check("rst_tx_data",   32'(bus.tx_data),   32'd0);
    check("rst_i_wr",      32'(bus.i_wr),      32'd0);
    check("rst_d_rd",      32'(bus.d_rd),      32'd0);
    check("rst_d_addr",    32'(bus.d_addr),    32'd0);
    check("rst_cpu_reset", 32'(cpu_reset_),    32'd0);
    check("rst_err",       32'(err),           32'd0);
    @(negedge clk) reset_ = 1'b1;

    // imem load of 3 bytes at 0x010
    send(8'h01); send(8'h00); send(8'h10); send(8'h00); send(8'h03);
    send(8'hAA); send(8'hBB); send(8'hCC);
`ifdef MEM_LOADER_CHECKSUM_EN
    send(8'hCF);
`endif
    wait_cycles(3);
    check("imem_count", 32'(iw_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) check("imem_wr", 32'(iw_q[i]), 32'(exp_i[i]));
    check("imem_cpu_reset", 32'(cpu_reset_), 32'd0);
    check("imem_d_wr_none", 32'(dw_q.size()), 32'd0);

    // dmem load at 0xFFE wraps through DMEM_BASE
    send(8'h02); send(8'h0F); send(8'hFE); send(8'h00); send(8'h04);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
`ifdef MEM_LOADER_CHECKSUM_EN
    send(8'h56);
`endif
    wait_cycles(3);
    check("dmem_count", 32'(dw_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("dmem_wr", 32'(dw_q[i]), 32'(exp_d[i]));
    check("dmem_idle", 32'(bus.rx_ready), 32'd1);
    check("dmem_err", 32'(err), 32'd0);

    // run: reset release after exactly COOLOFF cycles
    send(8'h04);
    check("cool_rx_ready", 32'(bus.rx_ready), 32'd0);
    n = 0;
    while (!cpu_reset_ && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("cooloff_cycles", 32'(n), 32'(COOLOFF));
    wait_cycles(4);
    check("run_rx_ready", 32'(bus.rx_ready), 32'd0);
    check("run_cpu_reset", 32'(cpu_reset_), 32'd1);
    cpu_halted = 1'b1;
    wait_cycles(2);
    check("halt_rx_ready", 32'(bus.rx_ready), 32'd1);
    check("halt_cpu_reset", 32'(cpu_reset_), 32'd1);
    cpu_halted = 1'b0;

    // preload dmem 0x008/0x009, then dump with backpressure
    send(8'h02); send(8'h00); send(8'h00); send(8'h00); send(8'h02);
    send(8'h5A); send(8'hA5);
`ifdef MEM_LOADER_CHECKSUM_EN
    send(8'h01);
`endif
    check("preload_cpu_reset", 32'(cpu_reset_), 32'd0);
    send(8'h03); send(8'h00); send(8'h00); send(8'h00); send(8'h02);
    n = 0;
    while (!bus.tx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("dump_first_valid", 32'(bus.tx_valid), 32'd1);
    check("dump_first_data", 32'(bus.tx_data), 32'h5A);
    repeat (5) @(negedge clk);
    check("dump_hold_valid", 32'(bus.tx_valid), 32'd1);
    check("dump_hold_data", 32'(bus.tx_data), 32'h5A);
    check("dump_hold_none", 32'(tx_q.size()), 32'd0);
    bus.tx_ready = 1'b1;
    n = 0;
    while (tx_q.size() < N_DUMP && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("dump_count", 32'(tx_q.size()), 32'(N_DUMP));
    for (int i = 0; i < N_DUMP; i++) check("dump_data", 32'(tx_q[i]), 32'(exp_tx[i]));
    check("dump_valid_drop", 32'(bus.tx_valid), 32'd0);
    bus.tx_ready = 1'b0;
    wait_cycles(2);
    check("dump_idle", 32'(bus.rx_ready), 32'd1);
    check("dump_err", 32'(err), 32'd0);

    // bad command, then zero-length load
    send(8'h07);
    wait_cycles(1);
    check("bad_cmd_err", 32'(err), 32'd1);
    check("bad_cmd_idle", 32'(bus.rx_ready), 32'd1);
    n0 = iw_q.size();
    send(8'h01); send(8'h00); send(8'h00); send(8'h00); send(8'h00);
    wait_cycles(3);
    check("zero_len_no_wr", 32'(iw_q.size()), 32'(n0));
    check("zero_len_idle", 32'(bus.rx_ready), 32'd1);
    check("err_sticky", 32'(err), 32'd1);

    // reset in the middle of a 4-byte imem load at 0x200
    send(8'h01); send(8'h02); send(8'h00); send(8'h00); send(8'h04);
    send(8'hC1); send(8'hC2);
    check("mid_last_wr", 32'(iw_q[iw_q.size()-1]), 32'h200C1);
    #2 reset_ = 1'b0;
    #1;
    check("mid_rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    check("mid_rst_i_wr", 32'(bus.i_wr), 32'd0);
    check("mid_rst_i_addr", 32'(bus.i_addr), 32'd0);
    check("mid_rst_i_data", 32'(bus.i_wr_data), 32'd0);
    check("mid_rst_cpu_reset", 32'(cpu_reset_), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    n0 = iw_q.size();
    @(negedge clk) reset_ = 1'b1;
    wait_cycles(10);
    check("post_rst_no_wr", 32'(iw_q.size()), 32'(n0));
    check("post_rst_idle", 32'(bus.rx_ready), 32'd1);
    // a leftover data byte is now parsed as an illegal command, not a write
    send(8'hC3);
    wait_cycles(3);
    check("no_resume_err", 32'(err), 32'd1);
    check("no_resume_no_wr", 32'(iw_q.size()), 32'(n0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
